// File: rtl/branch_sequencer.sv
// PC and branch-resolution stage: JMP/BCC/CALL/RET with a small return-address stack.
// Two cycles from request acceptance to the redirected pc; stall freezes both idle advance and EVAL.
module branch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          STACK_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        br_valid_i,
    input  logic [2:0]  br_type_i,
    input  logic [1:0]  br_cond_i,
    input  logic [15:0] br_target_i,
    input  logic        cmp_flag_i,
    output logic [1:0]  cmp_sel_o,
    output logic [15:0] pc_o,
    output logic        br_ack_o,
    output logic        busy_o,
    output logic        flush_o,
    output logic        stack_err_o
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    localparam logic [2:0] BR_JMP  = 3'b000;
    localparam logic [2:0] BR_BCC  = 3'b001;
    localparam logic [2:0] BR_CALL = 3'b010;
    localparam logic [2:0] BR_RET  = 3'b011;

    typedef enum logic {S_IDLE, S_EVAL} state_t;

    state_t            state_q, state_d;
    logic [15:0]       pc_q, pc_d;
    logic [1:0]        cmp_sel_q, cmp_sel_d;
    logic [2:0]        type_q, type_d;
    logic [15:0]       target_q, target_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [15:0]       stack_q [STACK_DEPTH];
    logic [15:0]       stack_d [STACK_DEPTH];
    logic              err_q, err_d;
    logic              ack_q, ack_d;
    logic              flush_q, flush_d;
    logic              busy_q, busy_d;

    logic [15:0]       pc_inc;
    logic [SP_W-1:0]   sp_dec;
    logic              stack_full;
    logic              stack_empty;

    assign pc_inc      = pc_q + 16'd1;
    assign sp_dec      = sp_q - SP_W'(1);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cmp_sel_d = cmp_sel_q;
        type_d    = type_q;
        target_d  = target_q;
        sp_d      = sp_q;
        stack_d   = stack_q;
        err_d     = err_q;
        ack_d     = 1'b0;
        flush_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!stall_i) begin
                    if (br_valid_i) begin
                        ack_d     = 1'b1;
                        type_d    = br_type_i;
                        target_d  = br_target_i;
                        cmp_sel_d = br_cond_i;
                        state_d   = S_EVAL;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            S_EVAL: begin
                if (!stall_i) begin
                    state_d = S_IDLE;
                    pc_d    = pc_inc;
                    case (type_q)
                        BR_JMP: begin
                            pc_d    = target_q;
                            flush_d = 1'b1;
                        end
                        BR_BCC: begin
                            if (cmp_flag_i) begin
                                pc_d    = target_q;
                                flush_d = 1'b1;
                            end
                        end
                        BR_CALL: begin
                            // Overflow leaves the stack untouched and falls through.
                            if (stack_full) begin
                                err_d = 1'b1;
                            end else begin
                                stack_d[sp_q[IDX_W-1:0]] = pc_inc;
                                sp_d    = sp_q + SP_W'(1);
                                pc_d    = target_q;
                                flush_d = 1'b1;
                            end
                        end
                        BR_RET: begin
                            if (stack_empty) begin
                                err_d = 1'b1;
                            end else begin
                                pc_d    = stack_q[sp_dec[IDX_W-1:0]];
                                sp_d    = sp_dec;
                                flush_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_EVAL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            cmp_sel_q <= 2'b00;
            type_q    <= 3'b000;
            target_q  <= 16'h0000;
            sp_q      <= '0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            flush_q   <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= 16'h0000;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cmp_sel_q <= cmp_sel_d;
            type_q    <= type_d;
            target_q  <= target_d;
            sp_q      <= sp_d;
            err_q     <= err_d;
            ack_q     <= ack_d;
            flush_q   <= flush_d;
            busy_q    <= busy_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    assign pc_o        = pc_q;
    assign cmp_sel_o   = cmp_sel_q;
    assign br_ack_o    = ack_q;
    assign busy_o      = busy_q;
    assign flush_o     = flush_q;
    assign stack_err_o = err_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed scenarios plus random traffic against a transaction-level model.
module tb_branch_sequencer;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_type = 3'b000;
    logic [1:0]  br_cond = 2'b00;
    logic [15:0] br_target = 16'h0000;
    logic        cmp_flag = 1'b0;
    logic [1:0]  cmp_sel;
    logic [15:0] pc;
    logic        br_ack;
    logic        busy;
    logic        flush;
    logic        stack_err;

    int checks = 0;
    int errors = 0;

    // Model: architectural pc, return-address stack as a queue, sticky error.
    logic [15:0] m_pc;
    logic [15:0] m_stack [$];
    logic        m_err;

    always #5 clk = ~clk;

    branch_sequencer #(.RESET_PC(RESET_PC), .STACK_DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .br_valid_i  (br_valid),
        .br_type_i   (br_type),
        .br_cond_i   (br_cond),
        .br_target_i (br_target),
        .cmp_flag_i  (cmp_flag),
        .cmp_sel_o   (cmp_sel),
        .pc_o        (pc),
        .br_ack_o    (br_ack),
        .busy_o      (busy),
        .flush_o     (flush),
        .stack_err_o (stack_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = RESET_PC;
        m_stack.delete();
        m_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; br_valid = 1'b0; stall = 1'b0;
        tick(); tick();
        model_reset();
        checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, RESET_PC); end
        checks++; if (cmp_sel !== 2'b00) begin errors++; $display("FAIL reset_cmp_sel got %b exp 00", cmp_sel); end
        checks++; if ({br_ack, busy, flush, stack_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got ack/busy/flush/err=%b exp 0000", {br_ack, busy, flush, stack_err});
        end
        rst = 1'b0;
    endtask

    task automatic idle_tick(input string name);
        br_valid = 1'b0; stall = 1'b0;
        tick();
        m_pc = m_pc + 16'd1;
        checks++; if (pc !== m_pc) begin errors++; $display("FAIL %s pc got %h exp %h", name, pc, m_pc); end
        checks++; if ({br_ack, busy, flush} !== 3'b000) begin
            errors++; $display("FAIL %s idle_flags got ack/busy/flush=%b exp 000", name, {br_ack, busy, flush});
        end
    endtask

    task automatic stalled_idle(input string name);
        br_valid = 1'b1; br_type = 3'($urandom_range(0, 3)); br_target = 16'($urandom);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc !== m_pc || br_ack !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL %s stalled_idle pc=%h ack=%b busy=%b exp pc=%h ack=0 busy=0", name, pc, br_ack, busy, m_pc);
            end
        end
        br_valid = 1'b0; stall = 1'b0;
    endtask

    // Issue one request from IDLE and follow it to resolution, checking every cycle.
    task automatic do_branch(input logic [2:0] t, input logic [1:0] c, input logic [15:0] tgt,
                             input logic f, input int nstall, input bit hold, input string name);
        logic [15:0] exp_pc;
        logic [15:0] ret_addr;
        logic        exp_fl;
        br_valid = 1'b1; br_type = t; br_cond = c; br_target = tgt; cmp_flag = f; stall = 1'b0;
        tick();
        checks++; if (br_ack !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL %s accept ack=%b busy=%b exp 1 1", name, br_ack, busy);
        end
        checks++; if (cmp_sel !== c) begin errors++; $display("FAIL %s cmp_sel got %b exp %b", name, cmp_sel, c); end
        checks++; if (pc !== m_pc || flush !== 1'b0) begin
            errors++; $display("FAIL %s accept_pc got %h flush=%b exp %h flush=0", name, pc, flush, m_pc);
        end
        if (!hold) begin
            br_valid = 1'b0; br_type = 3'($urandom); br_target = 16'($urandom);
        end
        stall = (nstall > 0);
        for (int i = 0; i < nstall; i++) begin
            tick();
            checks++; if (pc !== m_pc || busy !== 1'b1 || br_ack !== 1'b0 || flush !== 1'b0) begin
                errors++; $display("FAIL %s stall%0d pc=%h busy=%b ack=%b flush=%b exp pc=%h busy=1 ack=0 flush=0",
                                   name, i, pc, busy, br_ack, flush, m_pc);
            end
            if (i == nstall - 1) stall = 1'b0;
        end
        exp_fl = 1'b0;
        exp_pc = m_pc + 16'd1;
        case (t)
            3'd0: begin exp_pc = tgt; exp_fl = 1'b1; end
            3'd1: if (f) begin exp_pc = tgt; exp_fl = 1'b1; end
            3'd2: if (m_stack.size() < 4) begin
                      ret_addr = m_pc + 16'd1;
                      m_stack.push_back(ret_addr);
                      exp_pc = tgt; exp_fl = 1'b1;
                  end else m_err = 1'b1;
            3'd3: if (m_stack.size() > 0) begin
                      exp_pc = m_stack.pop_back(); exp_fl = 1'b1;
                  end else m_err = 1'b1;
            default: ;
        endcase
        m_pc = exp_pc;
        tick();
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL %s resolve_pc got %h exp %h", name, pc, exp_pc); end
        checks++; if (flush !== exp_fl) begin errors++; $display("FAIL %s flush got %b exp %b", name, flush, exp_fl); end
        checks++; if (busy !== 1'b0 || br_ack !== 1'b0) begin
            errors++; $display("FAIL %s resolve_flags busy=%b ack=%b exp 0 0", name, busy, br_ack);
        end
        checks++; if (stack_err !== m_err) begin errors++; $display("FAIL %s stack_err got %b exp %b", name, stack_err, m_err); end
        br_valid = 1'b0;
    endtask

    task automatic test_idle_count();
        for (int i = 0; i < 5; i++) idle_tick("idle_count");
    endtask

    task automatic test_bcc();
        do_branch(3'd0, 2'b00, 16'h0010, 1'b0, 0, 1'b0, "goto_0010");
        do_branch(3'd1, 2'b00, 16'h0040, 1'b1, 0, 1'b0, "bcc_taken");
        do_branch(3'd0, 2'b00, 16'h0010, 1'b0, 0, 1'b0, "goto_0010b");
        do_branch(3'd1, 2'b00, 16'h0040, 1'b0, 0, 1'b0, "bcc_not_taken");
        do_branch(3'd1, 2'b11, 16'h0777, 1'b1, 0, 1'b0, "bcc_ne");
    endtask

    task automatic test_stack();
        do_branch(3'd0, 2'b00, 16'h0100, 1'b0, 0, 1'b0, "goto_0100");
        for (int i = 1; i <= 5; i++) begin
            do_branch(3'd2, 2'b01, 16'(i * 256 + 256), 1'b0, 0, 1'b0, "call");
        end
        checks++; if (pc !== 16'h0501 || stack_err !== 1'b1) begin
            errors++; $display("FAIL call_overflow pc=%h err=%b exp 0501 1", pc, stack_err);
        end
        for (int i = 0; i < 5; i++) do_branch(3'd3, 2'b10, 16'hDEAD, 1'b0, 0, 1'b0, "ret");
        checks++; if (pc !== 16'h0102 || stack_err !== 1'b1) begin
            errors++; $display("FAIL ret_underflow pc=%h err=%b exp 0102 1", pc, stack_err);
        end
    endtask

    task automatic test_stall_eval();
        do_branch(3'd0, 2'b10, 16'h1234, 1'b0, 3, 1'b0, "jmp_stall3");
        idle_tick("after_stall");
    endtask

    task automatic test_wrap_and_hold();
        do_branch(3'd0, 2'b00, 16'hFFFF, 1'b0, 0, 1'b0, "goto_ffff");
        idle_tick("wrap");
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h exp 0000", pc); end
        do_branch(3'd0, 2'b01, 16'h0ABC, 1'b0, 1, 1'b1, "held_valid");
        idle_tick("held_after");
    endtask

    task automatic test_reset_in_eval();
        test_reset();
        do_branch(3'd2, 2'b00, 16'h0300, 1'b0, 0, 1'b0, "pre_call");
        br_valid = 1'b1; br_type = 3'd2; br_target = 16'h0900;
        tick();
        checks++; if (br_ack !== 1'b1) begin errors++; $display("FAIL rst_eval_ack got %b exp 1", br_ack); end
        br_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        checks++; if (pc !== RESET_PC || flush !== 1'b0 || busy !== 1'b0 || stack_err !== 1'b0) begin
            errors++; $display("FAIL rst_eval pc=%h flush=%b busy=%b err=%b exp %h 0 0 0", pc, flush, busy, stack_err, RESET_PC);
        end
        do_branch(3'd3, 2'b00, 16'h0555, 1'b0, 0, 1'b0, "ret_after_rst");
    endtask

    task automatic test_random();
        test_reset();
        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) idle_tick("rnd_idle");
            else if (r == 3) stalled_idle("rnd_stall");
            else do_branch(3'($urandom_range(0, 7)), 2'($urandom), 16'($urandom), 1'($urandom),
                           $urandom_range(0, 2), 1'($urandom_range(0, 1)), "rnd_br");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_count();
        test_bcc();
        test_stack();
        test_stall_eval();
        test_wrap_and_hold();
        test_reset_in_eval();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
